// File: rtl/dm_dtm_regs_pkg.sv
// Shared debug-transport types: DMI request/response payloads, DTM opcodes,
// DMI error codes, the DTMCS register layout and the JTAG IR codes.
package dm;

    // Address width carried by a DMI request.
    localparam int unsigned DmiAddrWidth = 7;

    // JTAG instruction register codes that select the two DTM data registers.
    localparam logic [4:0] IrDtmcs = 5'h10;
    localparam logic [4:0] IrDmi   = 5'h11;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        NoError = 2'd0,
        Failed  = 2'd2,
        Busy    = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [DmiAddrWidth-1:0] addr;
        dtm_op_e                 op;
        logic [31:0]             data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    // Build the read-only view of DTMCS returned on a capture.
    function automatic dtmcs_t dtmcs_capture(
        input logic [2:0] idle,
        input logic [1:0] dmistat,
        input logic [5:0] abits
    );
        dtmcs_t word;
        word              = '0;
        word.idle         = idle;
        word.dmistat      = dmistat;
        word.abits        = abits;
        word.version      = 4'd1;
        return word;
    endfunction

endpackage

// File: rtl/dm_dtm_regs.sv
// DTM data-register file and DMI master. Implements the DTMCS and DMI scan
// registers of a JTAG debug transport and turns DMI updates into requests
// towards the debug module, collecting the responses into data_q / error_q.
module dm_dtm_regs
    import dm::*;
#(
    parameter logic [2:0]  IdleCycles = 3'd1,
    parameter int unsigned DmiAbits   = 7
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      dtmcs_select_i,
    input  logic      dmi_select_i,
    input  logic      capture_dr_i,
    input  logic      shift_dr_i,
    input  logic      update_dr_i,
    input  logic      tdi_i,
    output logic      tdo_o,
    output logic      dmi_rst_no,
    output logic      dmi_req_valid_o,
    input  logic      dmi_req_ready_i,
    output dmi_req_t  dmi_req_o,
    input  logic      dmi_resp_valid_i,
    output logic      dmi_resp_ready_o,
    input  dmi_resp_t dmi_resp_i
);

    localparam int unsigned DrWidth = DmiAbits + 34;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StRead      = 3'd1;
    localparam logic [2:0] StWaitRead  = 3'd2;
    localparam logic [2:0] StWrite     = 3'd3;
    localparam logic [2:0] StWaitWrite = 3'd4;

    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic [1:0]          error_q;
    logic [1:0]          error_d;
    logic [DmiAbits-1:0] addr_q;
    logic [DmiAbits-1:0] addr_d;
    logic [31:0]         data_q;
    logic [31:0]         data_d;
    logic [DrWidth-1:0]  dr_q;
    logic [DrWidth-1:0]  dr_d;

    logic                req_valid_q;
    logic                resp_ready_q;
    logic                dmi_rst_q;
    dmi_req_t            dmi_req_q;
    dmi_req_t            req_next_s;
    logic                hardreset_s;
    logic [1:0]          dmi_op_s;
    dtmcs_t              dtmcs_s;

    // Next-state logic: DMI handshake first, TAP strobes on top so a
    // dmihardreset can override whatever the handshake decided this cycle.
    always_comb begin
        state_d     = state_q;
        error_d     = error_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dr_d        = dr_q;
        hardreset_s = 1'b0;
        dmi_op_s    = 2'b00;
        dtmcs_s     = dtmcs_capture(IdleCycles, error_q, 6'(DmiAbits));

        case (state_q)
            StRead: begin
                if (dmi_req_ready_i) begin
                    state_d = StWaitRead;
                end else begin
                    state_d = StRead;
                end
            end
            StWrite: begin
                if (dmi_req_ready_i) begin
                    state_d = StWaitWrite;
                end else begin
                    state_d = StWrite;
                end
            end
            StWaitRead: begin
                if (dmi_resp_valid_i) begin
                    state_d = StIdle;
                    data_d  = dmi_resp_i.data;
                    if ((dmi_resp_i.resp != 2'b00) && (error_q == 2'b00)) begin
                        error_d = Failed;
                    end else begin
                        error_d = error_q;
                    end
                end else begin
                    state_d = StWaitRead;
                end
            end
            StWaitWrite: begin
                if (dmi_resp_valid_i) begin
                    state_d = StIdle;
                    if ((dmi_resp_i.resp != 2'b00) && (error_q == 2'b00)) begin
                        error_d = Failed;
                    end else begin
                        error_d = error_q;
                    end
                end else begin
                    state_d = StWaitWrite;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Report the current error; an outstanding transaction seen by a
        // capture turns into a sticky busy error.
        if (error_q != 2'b00) begin
            dmi_op_s = error_q;
        end else if (state_q != StIdle) begin
            dmi_op_s = 2'b11;
        end else begin
            dmi_op_s = 2'b00;
        end

        if (capture_dr_i && (dtmcs_select_i || dmi_select_i)) begin
            if (dtmcs_select_i) begin
                dr_d       = '0;
                dr_d[31:0] = dtmcs_s;
            end else begin
                dr_d = {addr_q, data_q, dmi_op_s};
                if ((error_q == 2'b00) && (state_q != StIdle)) begin
                    error_d = Busy;
                end else begin
                    error_d = error_d;
                end
            end
        end else if (shift_dr_i && (dtmcs_select_i || dmi_select_i)) begin
            if (dtmcs_select_i) begin
                dr_d = {dr_q[DrWidth-1:32], tdi_i, dr_q[31:1]};
            end else begin
                dr_d = {tdi_i, dr_q[DrWidth-1:1]};
            end
        end else if (update_dr_i && (dtmcs_select_i || dmi_select_i)) begin
            if (dtmcs_select_i) begin
                if (dr_q[16]) begin
                    error_d = NoError;
                end else begin
                    error_d = error_d;
                end
                if (dr_q[17]) begin
                    state_d     = StIdle;
                    error_d     = NoError;
                    hardreset_s = 1'b1;
                end else begin
                    hardreset_s = 1'b0;
                end
            end else if (error_q != 2'b00) begin
                error_d = error_q;
            end else if (state_q != StIdle) begin
                error_d = Busy;
            end else begin
                addr_d = dr_q[DrWidth-1 -: DmiAbits];
                data_d = dr_q[33:2];
                case (dr_q[1:0])
                    2'd1:    state_d = StRead;
                    2'd2:    state_d = StWrite;
                    default: state_d = StIdle;
                endcase
            end
        end else begin
            dr_d = dr_q;
        end

        req_next_s.addr = addr_d;
        req_next_s.data = data_d;
        if (state_d == StWrite) begin
            req_next_s.op = DTM_WRITE;
        end else begin
            req_next_s.op = DTM_READ;
        end
    end

    // State, scan register and registered DMI-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            error_q      <= 2'b00;
            addr_q       <= '0;
            data_q       <= 32'd0;
            dr_q         <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            dmi_rst_q    <= 1'b1;
            dmi_req_q    <= '0;
        end else begin
            state_q      <= state_d;
            error_q      <= error_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            dr_q         <= dr_d;
            req_valid_q  <= (state_d == StRead) || (state_d == StWrite);
            resp_ready_q <= (state_d == StWaitRead) || (state_d == StWaitWrite);
            dmi_rst_q    <= ~hardreset_s;
            if ((state_d == StRead) || (state_d == StWrite)) begin
                dmi_req_q <= req_next_s;
            end else begin
                dmi_req_q <= dmi_req_q;
            end
        end
    end

    assign tdo_o            = dr_q[0];
    assign dmi_rst_no       = dmi_rst_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_req_o        = dmi_req_q;

endmodule

// File: doc/dm_dtm_regs.md
Name: dm_dtm_regs

Overview:
- Debug Transport Module register file and DMI master: implements the RISC-V Debug 0.13 `dtmcs` and `dmi` data registers behind a JTAG TAP.
- Issues DMI requests to the debug module and collects its responses.
- Sits directly upstream of the debug module top; its `dmi_req_*` / `dmi_resp_*` ports connect one-to-one to that block's DMI ports, through the DMI CDC when domains differ.
- Runs in a single clock domain (TCK); TAP state decode is done outside and arrives as one-cycle strobes.

Parameters:
- `IdleCycles`, 1, value reported in `dtmcs.idle[14:12]` (3 bits).
- `DmiAbits`, 7, DMI address width; reported in `dtmcs.abits[9:4]`; must equal the width of `dm::dmi_req_t.addr`.

Ports:
- `clk_i`, in, 1, clock (TCK).
- `rst_ni`, in, 1, asynchronous active-low reset (TRST / PoR).
- `dtmcs_select_i`, in, 1, IR currently selects DTMCS (0x10).
- `dmi_select_i`, in, 1, IR currently selects DMI (0x11).
- `capture_dr_i`, in, 1, TAP in Capture-DR this cycle.
- `shift_dr_i`, in, 1, TAP in Shift-DR this cycle.
- `update_dr_i`, in, 1, TAP in Update-DR this cycle.
- `tdi_i`, in, 1, serial data in.
- `tdo_o`, out, 1, serial data out, equal to `dr_q[0]`.
- `dmi_rst_no`, out, 1, DMI-side reset; low for one cycle on dmihardreset.
- `dmi_req_valid_o`, out, 1, DMI request valid.
- `dmi_req_ready_i`, in, 1, DM accepts request.
- `dmi_req_o`, out, `dm::dmi_req_t`, fields `{addr, op, data}`.
- `dmi_resp_valid_i`, in, 1, DM response valid.
- `dmi_resp_ready_o`, out, 1, DTM accepts response.
- `dmi_resp_i`, in, `dm::dmi_resp_t`, fields `{data[31:0], resp[1:0]}`.

Behaviour:
- **Reset values:** asynchronous reset on `rst_ni` low. All outputs reset as follows: `tdo_o`=0, `dmi_rst_no`=1, `dmi_req_valid_o`=0, `dmi_resp_ready_o`=0, `dmi_req_o`=0. Internal state resets as: FSM=Idle, `error_q`=0, `data_q`=0, `addr_q`=0, `dr_q`=0.
- **Shift register:** `dr_q` is 41 bits = `DmiAbits`+34. Strobe priority is capture > shift > update; strobes are ignored unless one select is high.
- **DTMCS capture:** `dr_q[31:0]` = {14'b0, 2'b0, 1'b0, `IdleCycles`[2:0], `error_q`[1:0], `DmiAbits`[5:0], 4'd1}. The upper `dr_q` bits are cleared.
- **DTMCS shift:** 32-bit shift right, `tdi_i` enters bit 31.
- **DTMCS update:**
  - bit 16 (dmireset) set: `error_q` cleared next cycle.
  - bit 17 (dmihardreset) set: FSM forced to Idle, `error_q` cleared, `dmi_req_valid_o` and `dmi_resp_ready_o` drop next cycle even mid-handshake, and `dmi_rst_no` is low for exactly one cycle.
- **DMI capture:**
  - `dr_q` = {`addr_q`, `data_q`, op}, where op = `error_q` if nonzero.
  - Else op = 2'b11 if FSM is not Idle; in that case `error_q` becomes 2'b11 (sticky busy).
  - Else op = 0.
- **DMI shift:** 41-bit shift right, `tdi_i` enters bit 40.
- **DMI update:**
  - If `error_q` is nonzero, ignored.
  - If FSM is not Idle, `error_q`=2'b11 and the request is ignored.
  - Else latch `addr_q`=`dr_q[40:34]` and `data_q`=`dr_q[33:2]`.
  - op 1 (read) → Read; op 2 (write) → Write; op 0 or 3 → stay Idle.
- **FSM states:** Idle, Read, WaitRead, Write, WaitWrite.
  - Read/Write: `dmi_req_valid_o`=1 with `dmi_req_o` = {`addr_q`, READ/WRITE, `data_q`}. Req fields stay stable while valid. On `dmi_req_ready_i`, go to WaitRead/WaitWrite. The request appears on the port the cycle after update.
  - WaitRead/WaitWrite: `dmi_resp_ready_o`=1. On `dmi_resp_valid_i`, return to Idle. In WaitRead, `data_q` ← `dmi_resp_i.data`. If `dmi_resp_i.resp` is nonzero, `error_q`=2'b10 (failed), unless `error_q` is already nonzero.
  - Request and response in the same cycle is impossible by protocol; the FSM consumes them in order regardless.
- **Error state:** `error_q` is sticky until dmireset, dmihardreset or `rst_ni`.

Decomposition:
- **Package `dm`:** `dmi_req_t`, `dmi_resp_t`, `dtm_op_e` (NOP/READ/WRITE), `dmi_error_e` (NoError=0, Failed=2, Busy=3), `dtmcs_t` packed struct, and the DTMCS/DMI IR constants.
- **Sub-module:** none; the block is a single module. The TAP controller stays a separate existing block.

Test Plan:
- DTMCS read after reset with `IdleCycles`=1, `DmiAbits`=7 → 32 bits shifted out on `tdo_o` = 0x00001071.
- DMI update with addr 0x10, data 0x00000001, op 2 → next cycle `dmi_req_valid_o`=1, `dmi_req_o` = {0x10, WRITE, 0x1}. Valid is held 3 cycles while `dmi_req_ready_i`=0, then drops after ready. The following capture returns op 0.
- DMI read of addr 0x11; DM returns data 0x00030382 with resp 0 → the next capture shifts out {0x11, 0x00030382, 0}.
- Capture while in WaitRead → op=3. A later write update issues no request. After DTMCS update with bit 16 set, `error_q`=0 and new requests are accepted.
- DM response with resp=2 → capture returns op=2, and the next DMI update is ignored.
- DTMCS update with bit 17 set while in Read with ready=0 → valid drops next cycle, `dmi_rst_no` low for 1 cycle, FSM Idle. `rst_ni` pulse mid-shift → `tdo_o`=0 and all state cleared.
